// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Define EX_MULDIV_EN to build the iterative multiply/divide unit and its front-end stall.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_EX_ReadData1,
  input  logic [31:0] ID_EX_ReadData2,
  input  logic [31:0] ID_EX_Imm,
  input  logic [4:0]  ID_EX_Rs,
  input  logic [4:0]  ID_EX_Rt,
  input  logic [4:0]  ID_EX_Rd,
  input  logic [3:0]  ID_EX_ALUOp,
  input  logic        ID_EX_ALUSrc,
  input  logic        ID_EX_RegDst,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_MemWrite,
  input  logic        ID_EX_MemToReg,
  input  logic        ID_EX_RegWrite,
  input  logic [31:0] EX_MEM_FwdData,
  input  logic [31:0] MEM_WB_WriteData,
  input  logic [4:0]  MEM_WB_WriteReg,
  input  logic        MEM_WB_RegWrite,
  output logic        EX_Stall,
  output logic [31:0] EX_MEM_ALUResult,
  output logic [31:0] EX_MEM_ReadData2,
  output logic [4:0]  EX_MEM_WriteReg,
  output logic        EX_MEM_MemRead,
  output logic        EX_MEM_MemWrite,
  output logic        EX_MEM_MemToReg,
  output logic        EX_MEM_RegWrite
);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_LUI   = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14, OP_PASSB = 4'd15;

  logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_result, ex_result;
  logic [4:0]  shamt, write_reg;

  // EX/MEM is the younger producer, so it is checked first; r0 is never forwarded.
  always_comb begin
    fwd_a = ID_EX_ReadData1;
    if (EX_MEM_RegWrite && EX_MEM_WriteReg != 5'd0 && EX_MEM_WriteReg == ID_EX_Rs)
      fwd_a = EX_MEM_FwdData;
    else if (MEM_WB_RegWrite && MEM_WB_WriteReg != 5'd0 && MEM_WB_WriteReg == ID_EX_Rs)
      fwd_a = MEM_WB_WriteData;
  end

  always_comb begin
    fwd_b = ID_EX_ReadData2;
    if (EX_MEM_RegWrite && EX_MEM_WriteReg != 5'd0 && EX_MEM_WriteReg == ID_EX_Rt)
      fwd_b = EX_MEM_FwdData;
    else if (MEM_WB_RegWrite && MEM_WB_WriteReg != 5'd0 && MEM_WB_WriteReg == ID_EX_Rt)
      fwd_b = MEM_WB_WriteData;
  end

  assign op_a      = fwd_a;
  assign op_b      = ID_EX_ALUSrc ? ID_EX_Imm : fwd_b;
  assign shamt     = op_b[4:0];
  assign write_reg = ID_EX_RegDst ? ID_EX_Rd : ID_EX_Rt;

  always_comb begin
    alu_result = 32'd0;
    case (ID_EX_ALUOp)
      OP_ADD:   alu_result = op_a + op_b;
      OP_SUB:   alu_result = op_a - op_b;
      OP_AND:   alu_result = op_a & op_b;
      OP_OR:    alu_result = op_a | op_b;
      OP_XOR:   alu_result = op_a ^ op_b;
      OP_NOR:   alu_result = ~(op_a | op_b);
      OP_SLT:   alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  alu_result = {31'd0, op_a < op_b};
      OP_SLL:   alu_result = op_a << shamt;
      OP_SRL:   alu_result = op_a >> shamt;
      OP_SRA:   alu_result = $unsigned($signed(op_a) >>> shamt);
      OP_LUI:   alu_result = op_b << 16;
      OP_PASSB: alu_result = op_b;
      default:  alu_result = 32'd0;
    endcase
  end

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t   md_state;
  logic [4:0]  md_count;
  logic [3:0]  md_op;
  logic [31:0] md_acc, md_x, md_y, md_result;
  logic [32:0] div_left, div_diff;
  logic        is_muldiv, div_fits;

  // MUL: acc += x while x shifts left and y (multiplier) shifts right.
  // DIVU/REMU: acc is the partial remainder, x the divisor, y shifts the dividend
  // out and the quotient in. A zero divisor naturally yields all-ones / dividend.
  assign is_muldiv = (ID_EX_ALUOp == OP_MUL) || (ID_EX_ALUOp == OP_DIVU) ||
                     (ID_EX_ALUOp == OP_REMU);
  assign div_left  = {md_acc, md_y[31]};
  assign div_fits  = div_left >= {1'b0, md_x};
  assign div_diff  = div_left - {1'b0, md_x};
  assign md_result = (md_op == OP_DIVU) ? md_y : md_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      md_state <= MD_IDLE;
      md_count <= 5'd0;
      md_op    <= 4'd0;
      md_acc   <= 32'd0;
      md_x     <= 32'd0;
      md_y     <= 32'd0;
    end else begin
      case (md_state)
        MD_IDLE: if (is_muldiv) begin
          md_op    <= ID_EX_ALUOp;
          md_count <= 5'd0;
          md_acc   <= 32'd0;
          md_x     <= (ID_EX_ALUOp == OP_MUL) ? op_a : op_b;
          md_y     <= (ID_EX_ALUOp == OP_MUL) ? op_b : op_a;
          md_state <= MD_BUSY;
        end
        MD_BUSY: begin
          if (md_op == OP_MUL) begin
            if (md_y[0]) md_acc <= md_acc + md_x;
            md_x <= md_x << 1;
            md_y <= md_y >> 1;
          end else begin
            md_acc <= div_fits ? div_diff[31:0] : div_left[31:0];
            md_y   <= {md_y[30:0], div_fits};
          end
          md_count <= md_count + 5'd1;
          if (md_count == 5'd31) md_state <= MD_DONE;
        end
        MD_DONE: md_state <= MD_IDLE;
        default: md_state <= MD_IDLE;
      endcase
    end
  end

  // EX_Stall contract: while high, upstream holds PC, IF/ID and ID/EX unchanged;
  // the instruction in ID/EX is consumed on the first rising edge with EX_Stall low.
  assign EX_Stall  = (md_state == MD_BUSY) || (md_state == MD_IDLE && is_muldiv);
  assign ex_result = (md_state == MD_DONE) ? md_result : alu_result;
`else
  assign EX_Stall  = 1'b0;
  assign ex_result = alu_result;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      EX_MEM_ALUResult <= 32'd0;
      EX_MEM_ReadData2 <= 32'd0;
      EX_MEM_WriteReg  <= 5'd0;
      EX_MEM_MemRead   <= 1'b0;
      EX_MEM_MemWrite  <= 1'b0;
      EX_MEM_MemToReg  <= 1'b0;
      EX_MEM_RegWrite  <= 1'b0;
    end else if (EX_Stall) begin
      EX_MEM_MemRead   <= 1'b0;
      EX_MEM_MemWrite  <= 1'b0;
      EX_MEM_MemToReg  <= 1'b0;
      EX_MEM_RegWrite  <= 1'b0;
    end else begin
      EX_MEM_ALUResult <= ex_result;
      EX_MEM_ReadData2 <= fwd_b;
      EX_MEM_WriteReg  <= write_reg;
      EX_MEM_MemRead   <= ID_EX_MemRead;
      EX_MEM_MemWrite  <= ID_EX_MemWrite;
      EX_MEM_MemToReg  <= ID_EX_MemToReg;
      EX_MEM_RegWrite  <= ID_EX_RegWrite;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table for forwarding/ALU, hand sequences for reset and,
// when EX_MULDIV_EN is defined, the multi-cycle multiply/divide unit.
module tb_ex_stage;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_LUI   = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14, OP_PASSB = 4'd15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd1, rd2, imm, fwd_data, wb_data;
  logic [4:0]  rs, rt, rd, wb_reg;
  logic [3:0]  alu_op;
  logic        alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write, wb_we;
  logic        ex_stall;
  logic [31:0] res, st_data;
  logic [4:0]  wreg;
  logic        o_mr, o_mw, o_mtr, o_rw;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  ex_stage dut (
    .clk(clk), .rst(rst),
    .ID_EX_ReadData1(rd1), .ID_EX_ReadData2(rd2), .ID_EX_Imm(imm),
    .ID_EX_Rs(rs), .ID_EX_Rt(rt), .ID_EX_Rd(rd),
    .ID_EX_ALUOp(alu_op), .ID_EX_ALUSrc(alu_src), .ID_EX_RegDst(reg_dst),
    .ID_EX_MemRead(mem_read), .ID_EX_MemWrite(mem_write),
    .ID_EX_MemToReg(mem_to_reg), .ID_EX_RegWrite(reg_write),
    .EX_MEM_FwdData(fwd_data), .MEM_WB_WriteData(wb_data),
    .MEM_WB_WriteReg(wb_reg), .MEM_WB_RegWrite(wb_we),
    .EX_Stall(ex_stall),
    .EX_MEM_ALUResult(res), .EX_MEM_ReadData2(st_data), .EX_MEM_WriteReg(wreg),
    .EX_MEM_MemRead(o_mr), .EX_MEM_MemWrite(o_mw),
    .EX_MEM_MemToReg(o_mtr), .EX_MEM_RegWrite(o_rw)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  op;
    logic        alu_src, reg_dst;
    logic [3:0]  ctrl;  // {MemRead, MemWrite, MemToReg, RegWrite}
    logic [31:0] fwd, wb_data;
    logic [4:0]  wb_reg;
    logic        wb_we;
    logic [31:0] exp_res, exp_rd2;
    logic [4:0]  exp_wreg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [4:0] f_rs, input logic [4:0] f_rt, input logic [4:0] f_rd,
    input logic [31:0] f_rd1, input logic [31:0] f_rd2, input logic [31:0] f_imm,
    input logic [3:0] f_op, input logic f_src, input logic f_dst, input logic [3:0] f_ctrl,
    input logic [31:0] f_fwd, input logic [31:0] f_wbd, input logic [4:0] f_wbr,
    input logic f_wbwe, input logic [31:0] f_res, input logic [31:0] f_erd2,
    input logic [4:0] f_ewreg);
    vec_t v;
    v.rs = f_rs; v.rt = f_rt; v.rd = f_rd; v.rd1 = f_rd1; v.rd2 = f_rd2; v.imm = f_imm;
    v.op = f_op; v.alu_src = f_src; v.reg_dst = f_dst; v.ctrl = f_ctrl;
    v.fwd = f_fwd; v.wb_data = f_wbd; v.wb_reg = f_wbr; v.wb_we = f_wbwe;
    v.exp_res = f_res; v.exp_rd2 = f_erd2; v.exp_wreg = f_ewreg;
    return v;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string name);
    check({name, " stall"},  {31'd0, ex_stall}, 32'd0);
    check({name, " result"}, res, 32'd0);
    check({name, " rd2"},    st_data, 32'd0);
    check({name, " wreg"},   {27'd0, wreg}, 32'd0);
    check({name, " ctrl"},   {28'd0, o_mr, o_mw, o_mtr, o_rw}, 32'd0);
  endtask

  // driver tasks
  task automatic drive_nop();
    rd1 = 32'd0; rd2 = 32'd0; imm = 32'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
    alu_op = OP_ADD; alu_src = 1'b0; reg_dst = 1'b0;
    {mem_read, mem_write, mem_to_reg, reg_write} = 4'b0000;
    fwd_data = 32'd0; wb_data = 32'd0; wb_reg = 5'd0; wb_we = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    rd1 = v.rd1; rd2 = v.rd2; imm = v.imm; rs = v.rs; rt = v.rt; rd = v.rd;
    alu_op = v.op; alu_src = v.alu_src; reg_dst = v.reg_dst;
    {mem_read, mem_write, mem_to_reg, reg_write} = v.ctrl;
    fwd_data = v.fwd; wb_data = v.wb_data; wb_reg = v.wb_reg; wb_we = v.wb_we;
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    @(negedge clk);
    drive_vec(v);
    exp_q.push_back(v.exp_res);
    #1 check({name, " stall"}, {31'd0, ex_stall}, 32'd0);
    @(posedge clk);
    #1;
    check({name, " result"}, res, exp_q.pop_front());
    check({name, " rd2"},    st_data, v.exp_rd2);
    check({name, " wreg"},   {27'd0, wreg}, {27'd0, v.exp_wreg});
    check({name, " ctrl"},   {28'd0, o_mr, o_mw, o_mtr, o_rw}, {28'd0, v.ctrl});
  endtask

`ifdef EX_MULDIV_EN
  // Op enters at cycle t: expect 33 stalled cycles of bubbles, then the result at t+34.
  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit a_from_wb);
    int n;
    bit bubble_bad;
    n = 0;
    bubble_bad = 1'b0;
    @(negedge clk);
    drive_nop();
    rs = 5'd13; rt = 5'd14; rd = 5'd15; reg_dst = 1'b1; alu_op = op; reg_write = 1'b1;
    rd2 = b;
    if (a_from_wb) begin
      rd1 = 32'h0BAD_0BAD; wb_reg = 5'd13; wb_we = 1'b1; wb_data = a;
    end else begin
      rd1 = a;
    end
    exp_q.push_back(exp);
    #1;
    while (ex_stall && n < 40) begin
      n++;
      @(posedge clk);
      #1;
      if (o_rw !== 1'b0 || o_mr !== 1'b0 || o_mw !== 1'b0 || o_mtr !== 1'b0) bubble_bad = 1'b1;
      // Forwarding sources change after the op was latched; they must be ignored.
      wb_we = 1'b0; wb_data = 32'hFFFF_FFFF; fwd_data = 32'h1357_9BDF;
      @(negedge clk);
      #1;
    end
    check({name, " stall cycles"}, n, 32'd33);
    check({name, " bubbles"}, {31'd0, bubble_bad}, 32'd0);
    @(posedge clk);
    #1;
    check({name, " result"}, res, exp_q.pop_front());
    check({name, " wreg"},   {27'd0, wreg}, 32'd15);
    check({name, " ctrl"},   {28'd0, o_mr, o_mw, o_mtr, o_rw}, 32'd1);
  endtask
`endif

  initial begin
    int stall_seen;
    // vector table: each row depends on the EX/MEM state left by the row before
    vecs.push_back(mk(1, 2, 5, 32'hC, 32'h77, 32'h4, OP_ADD, 1, 1, 4'b0001,
                      0, 0, 0, 0, 32'h10, 32'h77, 5));
    vecs.push_back(mk(5, 6, 7, 32'hDEAD, 32'h3, 0, OP_ADD, 0, 1, 4'b0001,
                      32'h10, 32'h20, 5, 1, 32'h13, 32'h3, 7));
    vecs.push_back(mk(1, 0, 7, 32'h100, 32'h9, 32'h5, OP_ADD, 1, 0, 4'b0001,
                      32'h10, 32'h99, 0, 1, 32'h105, 32'h9, 0));
    vecs.push_back(mk(0, 8, 0, 32'h40, 32'h2, 0, OP_ADD, 0, 0, 4'b0100,
                      32'h555, 32'h666, 0, 1, 32'h42, 32'h2, 8));
    vecs.push_back(mk(4, 8, 9, 32'h1000, 32'h1, 0, OP_SUB, 0, 1, 4'b1011,
                      32'h999, 32'h234, 8, 1, 32'hDCC, 32'h234, 9));
    vecs.push_back(mk(10, 11, 12, 32'hFFFF_FFFF, 32'h1, 0, OP_SLT, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'h1, 32'h1, 12));
    vecs.push_back(mk(10, 11, 12, 32'hFFFF_FFFF, 32'h1, 0, OP_SLTU, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'h0, 32'h1, 12));
    vecs.push_back(mk(10, 11, 12, 32'h8000_0000, 32'h1, 32'h4, OP_SRA, 1, 1, 4'b0001,
                      0, 0, 0, 0, 32'hF800_0000, 32'h1, 12));
    vecs.push_back(mk(10, 11, 12, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, OP_AND, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'h00F0_1234, 32'h0FF0_FFFF, 12));
    vecs.push_back(mk(10, 11, 12, 32'hF000_0000, 32'h0000_000F, 0, OP_OR, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'hF000_000F, 32'h0000_000F, 12));
    vecs.push_back(mk(10, 11, 12, 32'hFFFF_0000, 32'hFF00_FF00, 0, OP_XOR, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'h00FF_FF00, 32'hFF00_FF00, 12));
    vecs.push_back(mk(10, 11, 12, 32'hF0F0_F0F0, 32'h0F0F_0000, 0, OP_NOR, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'h0000_0F0F, 32'h0F0F_0000, 12));
    vecs.push_back(mk(10, 11, 12, 32'h1, 32'h5, 32'h3F, OP_SLL, 1, 1, 4'b0001,
                      0, 0, 0, 0, 32'h8000_0000, 32'h5, 12));
    vecs.push_back(mk(10, 11, 12, 32'h8000_0000, 32'h5, 32'h4, OP_SRL, 1, 1, 4'b0001,
                      0, 0, 0, 0, 32'h0800_0000, 32'h5, 12));
    vecs.push_back(mk(10, 11, 12, 32'hAAAA, 32'h5, 32'h1234, OP_LUI, 1, 1, 4'b0001,
                      0, 0, 0, 0, 32'h1234_0000, 32'h5, 12));
    vecs.push_back(mk(10, 11, 12, 32'hAAAA, 32'h5, 32'hCAFE_BABE, OP_PASSB, 1, 1, 4'b0001,
                      0, 0, 0, 0, 32'hCAFE_BABE, 32'h5, 12));
    vecs.push_back(mk(10, 11, 12, 32'hFFFF_FFFF, 32'h2, 0, OP_ADD, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'h1, 32'h2, 12));
    vecs.push_back(mk(10, 11, 12, 32'h0, 32'h1, 0, OP_SUB, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'hFFFF_FFFF, 32'h1, 12));
`ifndef EX_MULDIV_EN
    vecs.push_back(mk(10, 11, 12, 32'h5, 32'h7, 0, OP_MUL, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'h0, 32'h7, 12));
    vecs.push_back(mk(10, 11, 12, 32'd100, 32'd7, 0, OP_DIVU, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'h0, 32'd7, 12));
    vecs.push_back(mk(10, 11, 12, 32'd100, 32'd7, 0, OP_REMU, 0, 1, 4'b0001,
                      0, 0, 0, 0, 32'h0, 32'd7, 12));
`endif

    // initial reset
    rst = 1'b1;
    drive_nop();
    repeat (2) @(posedge clk);
    #1 check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply_vec($sformatf("v%0d", i), vecs[i]);

    // mid-stream reset held two cycles while a writing instruction is presented
    @(negedge clk);
    rst = 1'b1;
    drive_vec(vecs[0]);
    @(posedge clk);
    #1 check_cleared("midrst1");
    @(posedge clk);
    #1 check_cleared("midrst2");
    @(negedge clk);
    rst = 1'b0;
    apply_vec("post_rst", mk(1, 2, 3, 32'h7, 32'h8, 0, OP_ADD, 0, 1, 4'b0001,
                             0, 0, 0, 0, 32'hF, 32'h8, 3));

`ifdef EX_MULDIV_EN
    run_md("mul", OP_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b1);
    run_md("mul_ff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0);
    run_md("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    run_md("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    run_md("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0);
    run_md("divu_z", OP_DIVU, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1'b0);
    run_md("remu_z", OP_REMU, 32'd9, 32'h0, 32'd9, 1'b0);
    @(negedge clk);
    drive_nop();
    #1 check("no_retrigger stall", {31'd0, ex_stall}, 32'd0);

    // reset in the middle of BUSY discards the op
    @(negedge clk);
    drive_nop();
    rs = 5'd13; rt = 5'd14; rd = 5'd15; reg_dst = 1'b1; alu_op = OP_MUL; reg_write = 1'b1;
    rd1 = 32'h1234; rd2 = 32'h10;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_nop();
    @(posedge clk);
    #1 check_cleared("busy_rst");
    @(negedge clk);
    rst = 1'b0;
    apply_vec("after_busy_rst", mk(1, 2, 3, 32'h21, 32'h21, 0, OP_ADD, 0, 1, 4'b0001,
                                   0, 0, 0, 0, 32'h42, 32'h21, 3));
    stall_seen = 0;
    @(negedge clk);
    drive_nop();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ex_stall || o_rw) stall_seen++;
    end
    check("discarded op activity", stall_seen, 32'd0);
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipeline: takes the decoded instruction from the ID/EX register, resolves operand hazards by forwarding from EX/MEM and MEM/WB, and computes the ALU result. When compiled in, it also runs an iterative multiply/divide unit that stalls the front end. It contains the EX/MEM pipeline register, whose outputs drive the MEM stage directly.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ID_EX_ReadData1, ID_EX_ReadData2  in  32  register file operands A, B
- ID_EX_Imm  in  32  sign-extended immediate
- ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  in  5  register specifiers
- ID_EX_ALUOp  in  4  operation code (see Operation)
- ID_EX_ALUSrc  in  1  1 = second operand is ID_EX_Imm
- ID_EX_RegDst  in  1  1 = destination is Rd, else Rt
- ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_RegWrite  in  1  control, carried forward
- EX_MEM_FwdData  in  32  fed back from own EX_MEM_ALUResult
- MEM_WB_WriteData  in  32  final WB-mux value
- MEM_WB_WriteReg  in  5  MEM/WB destination register
- MEM_WB_RegWrite  in  1  MEM/WB write enable
- EX_Stall  out  1  freeze PC, IF/ID and ID/EX
- EX_MEM_ALUResult, EX_MEM_ReadData2  out  32  to MEM stage
- EX_MEM_WriteReg  out  5  to MEM stage
- EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite  out  1  to MEM stage

## Operation
Forwarding (per source X = Rs / Rt):
- If EX_MEM_RegWrite && EX_MEM_WriteReg != 0 && EX_MEM_WriteReg == X, use EX_MEM_FwdData.
- Otherwise, if MEM_WB_RegWrite && MEM_WB_WriteReg != 0 && MEM_WB_WriteReg == X, use MEM_WB_WriteData.
- Otherwise, use ReadData1 / ReadData2.
- EX/MEM has priority over MEM/WB.
- Load-use hazards are resolved by the ID hazard unit, never here.

Operand selection:
- A = forwarded Rs value.
- B = ID_EX_Imm if ALUSrc, else forwarded Rt value.
- EX_MEM_ReadData2 always takes the forwarded Rt value (store data).
- WriteReg = Rd if RegDst, else Rt.

ALUOp, 32-bit wrap-around results:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
- 6 SLT (signed, result 0/1), 7 SLTU (unsigned, result 0/1)
- 8 SLL, 9 SRL, 10 SRA: shift A by B[4:0]
- 11 LUI: B<<16
- 12 MUL: low 32 bits of A*B
- 13 DIVU: A/B unsigned
- 14 REMU: A%B unsigned
- 15 PASSB: B

Multiply/divide FSM (ops 12–14), states IDLE, BUSY, DONE:
- IDLE with a mul/div op present: latch A, B and op; counter=0; EX_Stall=1; go to BUSY.
- BUSY: one shift-add (MUL) or restoring-divide step (DIVU/REMU) per cycle; EX_Stall=1. After counter reaches 31, go to DONE.
- DONE: EX_Stall=0; the latched result feeds the EX/MEM register; go to IDLE.
- Divide by zero: DIVU = 0xFFFFFFFF, REMU = A. No trap.

EX/MEM register:
- Loads every cycle.
- While EX_Stall=1 it loads a bubble: all control outputs 0; data and WriteReg keep their previous values.

## Timing
- Reset: every output is 0, the FSM is IDLE, EX_Stall=0.
- Single-cycle ops: result visible on EX_MEM_* one cycle after the instruction is in ID/EX.
- Mul/div op entering EX at cycle t:
  - EX_Stall is 1 for cycles t..t+32 (33 cycles), combinational from state and ALUOp.
  - DONE occurs at t+33; the result appears on EX_MEM_* at t+34.
- Upstream holds ID/EX stable while EX_Stall=1. The operands latched at t are used, so later changes on the forwarding inputs are ignored.
- The DONE cycle must not re-trigger the same op.
- Back-to-back mul/div ops: the second one starts in the cycle after DONE.
- rst in any FSM state: IDLE, EX_Stall=0 and bubble outputs on the next edge. The in-flight op is discarded.

## Configuration
- EX_MULDIV_EN defined: the FSM, iterative datapath and EX_Stall behaviour exist as described.
- Undefined: ALUOp 12–14 produce 0 in a single cycle, EX_Stall is tied to 0, and no FSM is synthesized.

## Test plan
- Reset: hold rst 2 cycles mid-stream -> all EX_MEM_* = 0, EX_Stall = 0.
- ADD with double hazard: Rs=5; EX_MEM writes r5=0x10; MEM_WB writes r5=0x20; ReadData2=3 -> EX_MEM_ALUResult=0x13 (EX/MEM wins). Repeat with Rs=0 -> uses ReadData1.
- Signed compare: SLT A=0xFFFFFFFF, B=1 -> result 1. SLTU on the same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
- MUL 0x10000 × 0x10001 -> EX_Stall high for exactly 33 cycles, bubbles on EX_MEM_RegWrite, then ALUResult=0x00010000 with RegWrite=1 at t+34.
- DIVU 100/7 -> 14; REMU 100%7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 9%0 -> 9.
- Reset asserted at BUSY cycle 10 -> EX_Stall=0 on the next edge, no result is written, and the next ADD completes normally.
